// File: rtl/rec_play_mem_ctrl.sv
// Record/playback arbiter for a single shared sample memory: records RecData words, then replays them with optional looping.
// Latency: FSM reacts one cycle after a button pulse; MemWE/RecReady follow RecValid combinationally while recording.
// Backpressure: RecReady mirrors RecValid in RECORD only; writes offered in any other state are dropped.
module rec_play_mem_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 12
) (
  input  logic              PCLK,
  input  logic              PBrst,
  input  logic              RecBtn,
  input  logic              PlayBtn,
  input  logic              StopBtn,
  input  logic              Loop,
  input  logic              RecValid,
  input  logic [DATA_W-1:0] RecData,
  input  logic [ADDR_W-1:0] PlayAddr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              MemWE,
  output logic              ReadEn,
  output logic              PlayRst,
  output logic              RecReady,
  output logic [ADDR_W-1:0] EndAddr,
  output logic              HasData,
  output logic              Full,
  output logic [1:0]        State
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECORD  = 2'd1,
    PLAYRST = 2'd2,
    PLAY    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, prev_addr, end_addr;
  logic              has_data, full;
  logic              wr_acc, last_wr, end_of_rec;

  assign wr_acc  = (state == RECORD) && RecValid;
  assign last_wr = wr_acc && (wr_ptr == LAST_ADDR);
  // Compare against the previous address so a 0x7FF->0 wrap on a full recording is still seen.
  assign end_of_rec = (state == PLAY) && (prev_addr == end_addr) && (PlayAddr != end_addr);

  always_ff @(posedge PCLK) begin
    if (PBrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (StopBtn)                 state_nxt = IDLE;
        else if (RecBtn)             state_nxt = RECORD;
        else if (PlayBtn && has_data) state_nxt = PLAYRST;
      end
      RECORD:  if (StopBtn || last_wr) state_nxt = IDLE;
      PLAYRST: state_nxt = StopBtn ? IDLE : PLAY;
      PLAY: begin
        if (StopBtn)         state_nxt = IDLE;
        else if (end_of_rec) state_nxt = Loop ? PLAYRST : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MemAddr   = '0;
    MemWrData = '0;
    MemWE     = 1'b0;
    RecReady  = 1'b0;
    ReadEn    = 1'b0;
    PlayRst   = 1'b0;
    case (state)
      RECORD: begin
        MemAddr   = wr_ptr;
        MemWrData = RecData;
        MemWE     = RecValid;
        RecReady  = RecValid;
      end
      PLAYRST: PlayRst = 1'b1;
      PLAY: begin
        ReadEn  = 1'b1;
        MemAddr = PlayAddr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PBrst) begin
      wr_ptr    <= '0;
      prev_addr <= '0;
      end_addr  <= '0;
      has_data  <= 1'b0;
      full      <= 1'b0;
    end else begin
      prev_addr <= PlayAddr;
      if (state == IDLE && state_nxt == RECORD) begin
        wr_ptr   <= '0;
        has_data <= 1'b0;
        full     <= 1'b0;
      end
      if (state == RECORD) begin
        if (last_wr) begin
          full     <= 1'b1;
          has_data <= 1'b1;
          end_addr <= LAST_ADDR;
        end else begin
          if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
          // A write landing with the stop pulse is the last word of the take.
          if (StopBtn) begin
            if (wr_acc) begin
              end_addr <= wr_ptr;
              has_data <= 1'b1;
            end else if (wr_ptr != '0) begin
              end_addr <= wr_ptr - 1'b1;
              has_data <= 1'b1;
            end else begin
              end_addr <= '0;
              has_data <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign EndAddr = end_addr;
  assign HasData = has_data;
  assign Full    = full;
  assign State   = state;

endmodule

// File: tb/tb_rec_play_mem_ctrl.sv
// Directed bench for rec_play_mem_ctrl: vector table for short sequences, hand sequences for full-memory and reset cases.
module tb_rec_play_mem_ctrl;

  logic        PCLK = 1'b0;
  logic        PBrst, RecBtn, PlayBtn, StopBtn, Loop, RecValid;
  logic [11:0] RecData;
  logic [10:0] PlayAddr;
  logic [10:0] MemAddr, EndAddr;
  logic [11:0] MemWrData;
  logic        MemWE, ReadEn, PlayRst, RecReady, HasData, Full;
  logic [1:0]  State;

  int n_cmp = 0;
  int n_bad = 0;

  rec_play_mem_ctrl #(.ADDR_W(11), .DATA_W(12)) dut (
    .PCLK(PCLK), .PBrst(PBrst), .RecBtn(RecBtn), .PlayBtn(PlayBtn), .StopBtn(StopBtn),
    .Loop(Loop), .RecValid(RecValid), .RecData(RecData), .PlayAddr(PlayAddr),
    .MemAddr(MemAddr), .MemWrData(MemWrData), .MemWE(MemWE), .ReadEn(ReadEn),
    .PlayRst(PlayRst), .RecReady(RecReady), .EndAddr(EndAddr), .HasData(HasData),
    .Full(Full), .State(State)
  );

  always #5 PCLK = ~PCLK;

  // Playback unit model: address clears on PlayRst and advances while enabled.
  always @(posedge PCLK) begin
    if (PBrst || PlayRst) PlayAddr <= '0;
    else if (ReadEn)      PlayAddr <= PlayAddr + 1'b1;
  end

  // in = {rst, rec, play, stop, loop, vld}; out = {we, ren, prst, has, full}
  typedef struct packed {
    logic [5:0]  in;
    logic [11:0] data;
    logic [1:0]  st;
    logic [4:0]  out;
    logic [10:0] ea;
    logic [10:0] ma;
    logic [11:0] wd;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] in, input logic [11:0] data);
    {PBrst, RecBtn, PlayBtn, StopBtn, Loop, RecValid} = in;
    RecData = data;
  endtask

  initial begin
    int pulses, cyc, saw_idle;
    vec_t t;

    tbl.push_back({6'b100000, 12'h000, 2'd0, 5'b00000, 11'h000, 11'h000, 12'h000});
    tbl.push_back({6'b010000, 12'h000, 2'd0, 5'b00000, 11'h000, 11'h000, 12'h000});
    tbl.push_back({6'b000001, 12'h011, 2'd1, 5'b10000, 11'h000, 11'h000, 12'h011});
    tbl.push_back({6'b000001, 12'h012, 2'd1, 5'b10000, 11'h000, 11'h001, 12'h012});
    tbl.push_back({6'b000001, 12'h013, 2'd1, 5'b10000, 11'h000, 11'h002, 12'h013});
    tbl.push_back({6'b000001, 12'h014, 2'd1, 5'b10000, 11'h000, 11'h003, 12'h014});
    tbl.push_back({6'b000001, 12'h015, 2'd1, 5'b10000, 11'h000, 11'h004, 12'h015});
    tbl.push_back({6'b000100, 12'h000, 2'd1, 5'b00000, 11'h000, 11'h005, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd0, 5'b00010, 11'h004, 11'h000, 12'h000});
    tbl.push_back({6'b001000, 12'h000, 2'd0, 5'b00010, 11'h004, 11'h000, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd2, 5'b00110, 11'h004, 11'h000, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd3, 5'b01010, 11'h004, 11'h000, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd3, 5'b01010, 11'h004, 11'h001, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd3, 5'b01010, 11'h004, 11'h002, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd3, 5'b01010, 11'h004, 11'h003, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd3, 5'b01010, 11'h004, 11'h004, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd3, 5'b01010, 11'h004, 11'h005, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd0, 5'b00010, 11'h004, 11'h000, 12'h000});
    tbl.push_back({6'b011000, 12'h000, 2'd0, 5'b00010, 11'h004, 11'h000, 12'h000});
    tbl.push_back({6'b000100, 12'h000, 2'd1, 5'b00000, 11'h004, 11'h000, 12'h000});
    tbl.push_back({6'b001000, 12'h000, 2'd0, 5'b00000, 11'h000, 11'h000, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd0, 5'b00000, 11'h000, 11'h000, 12'h000});
    tbl.push_back({6'b010100, 12'h000, 2'd0, 5'b00000, 11'h000, 11'h000, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd0, 5'b00000, 11'h000, 11'h000, 12'h000});
    tbl.push_back({6'b010000, 12'h000, 2'd0, 5'b00000, 11'h000, 11'h000, 12'h000});
    tbl.push_back({6'b000001, 12'h0A5, 2'd1, 5'b10000, 11'h000, 11'h000, 12'h0A5});
    tbl.push_back({6'b000101, 12'h0B6, 2'd1, 5'b10000, 11'h000, 11'h001, 12'h0B6});
    tbl.push_back({6'b001010, 12'h000, 2'd0, 5'b00010, 11'h001, 11'h000, 12'h000});
    tbl.push_back({6'b010010, 12'h000, 2'd2, 5'b00110, 11'h001, 11'h000, 12'h000});
    tbl.push_back({6'b010010, 12'h000, 2'd3, 5'b01010, 11'h001, 11'h000, 12'h000});
    tbl.push_back({6'b000010, 12'h000, 2'd3, 5'b01010, 11'h001, 11'h001, 12'h000});
    tbl.push_back({6'b000010, 12'h000, 2'd3, 5'b01010, 11'h001, 11'h002, 12'h000});
    tbl.push_back({6'b000010, 12'h000, 2'd2, 5'b00110, 11'h001, 11'h000, 12'h000});
    tbl.push_back({6'b000110, 12'h000, 2'd3, 5'b01010, 11'h001, 11'h000, 12'h000});
    tbl.push_back({6'b000000, 12'h000, 2'd0, 5'b00010, 11'h001, 11'h000, 12'h000});

    drive(6'b100000, 12'h000);
    repeat (2) @(posedge PCLK);

    for (int i = 0; i < tbl.size(); i++) begin
      t = tbl[i];
      @(negedge PCLK);
      drive(t.in, t.data);
      #1;
      chk($sformatf("v%0d_state", i), 32'(State), 32'(t.st));
      chk($sformatf("v%0d_we", i), 32'(MemWE), 32'(t.out[4]));
      chk($sformatf("v%0d_rdy", i), 32'(RecReady), 32'(t.out[4]));
      chk($sformatf("v%0d_ren", i), 32'(ReadEn), 32'(t.out[3]));
      chk($sformatf("v%0d_prst", i), 32'(PlayRst), 32'(t.out[2]));
      chk($sformatf("v%0d_has", i), 32'(HasData), 32'(t.out[1]));
      chk($sformatf("v%0d_full", i), 32'(Full), 32'(t.out[0]));
      chk($sformatf("v%0d_end", i), 32'(EndAddr), 32'(t.ea));
      chk($sformatf("v%0d_maddr", i), 32'(MemAddr), 32'(t.ma));
      chk($sformatf("v%0d_wdata", i), 32'(MemWrData), 32'(t.wd));
      chk($sformatf("v%0d_we_ren_excl", i), 32'(MemWE & ReadEn), 32'd0);
    end

    // Fill the whole memory; controller must stop by itself on the last address.
    @(negedge PCLK); drive(6'b010000, 12'h000);
    for (int i = 0; i < 2048; i++) begin
      @(negedge PCLK);
      drive(6'b000001, 12'(i));
      #1;
      chk($sformatf("full_wr_addr_%0d", i), 32'(MemAddr), 32'(i));
    end
    @(negedge PCLK); drive(6'b000000, 12'h000);
    #1;
    chk("full_auto_idle", 32'(State), 32'd0);
    chk("full_flag", 32'(Full), 32'd1);
    chk("full_has", 32'(HasData), 32'd1);
    chk("full_end", 32'(EndAddr), 32'h7FF);
    chk("full_we_off", 32'(MemWE), 32'd0);

    // Looped playback across the 0x7FF->0 wrap must restart without dropping to IDLE.
    @(negedge PCLK); drive(6'b001010, 12'h000);
    pulses = 0; cyc = 0; saw_idle = 0;
    while (pulses < 2 && cyc < 2200) begin
      @(negedge PCLK); drive(6'b000010, 12'h000);
      #1;
      if (PlayRst) pulses++;
      if (State == 2'd0) saw_idle = 1;
      cyc++;
    end
    chk("loop_prst_pulses", 32'(pulses), 32'd2);
    chk("loop_no_idle", 32'(saw_idle), 32'd0);
    @(negedge PCLK); #1;
    chk("loop_back_in_play", 32'(State), 32'd3);
    chk("loop_ren", 32'(ReadEn), 32'd1);

    // Reset mid-play, with competing buttons.
    drive(6'b111010, 12'h000);
    @(negedge PCLK); drive(6'b000000, 12'h000);
    #1;
    chk("rst_play_state", 32'(State), 32'd0);
    chk("rst_play_ren", 32'(ReadEn), 32'd0);
    chk("rst_play_prst", 32'(PlayRst), 32'd0);
    chk("rst_play_has", 32'(HasData), 32'd0);
    chk("rst_play_full", 32'(Full), 32'd0);
    chk("rst_play_end", 32'(EndAddr), 32'd0);
    chk("rst_play_maddr", 32'(MemAddr), 32'd0);

    // Reset mid-record at wr_ptr=100 with RecValid held high.
    @(negedge PCLK); drive(6'b010000, 12'h000);
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK); drive(6'b000001, 12'(i + 'h200));
    end
    @(negedge PCLK); drive(6'b000001, 12'h123);
    #1;
    chk("rec100_addr", 32'(MemAddr), 32'd100);
    chk("rec100_we", 32'(MemWE), 32'd1);
    drive(6'b110001, 12'h123);
    @(negedge PCLK); drive(6'b000001, 12'h123);
    #1;
    chk("rst_rec_state", 32'(State), 32'd0);
    chk("rst_rec_we", 32'(MemWE), 32'd0);
    chk("rst_rec_rdy", 32'(RecReady), 32'd0);
    chk("rst_rec_ren", 32'(ReadEn), 32'd0);
    chk("rst_rec_has", 32'(HasData), 32'd0);
    chk("rst_rec_end", 32'(EndAddr), 32'd0);
    chk("rst_rec_maddr", 32'(MemAddr), 32'd0);
    chk("rst_rec_wdata", 32'(MemWrData), 32'd0);

    // After reset the write pointer restarts from zero.
    @(negedge PCLK); drive(6'b010000, 12'h000);
    @(negedge PCLK); drive(6'b000001, 12'h3C3);
    #1;
    chk("rerec_addr0", 32'(MemAddr), 32'd0);
    @(negedge PCLK); drive(6'b000000, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
